// File: rtl/unified_cache_mem_ctrl_pkg.sv
// Shared packet field layout, FSM encoding and fill-packet helper for the
// memory-side controller that sits behind the unified cache.
package unified_cache_mem_ctrl_pkg;

    localparam int VALID_POS         = 0;
    localparam int IS_WRITE_POS      = 1;
    localparam int PORT_NUM_LO       = 2;
    localparam int PORT_NUM_HI       = 3;
    localparam int ADDR_LO           = 4;
    localparam int ADDR_HI           = 35;
    localparam int DATA_LO           = 36;
    localparam int DATA_HI           = 67;
    localparam int PACKET_WIDTH_BITS = DATA_HI + 1;

    typedef enum logic [1:0] {
        MEM_CTRL_STATE_IDLE    = 2'd0,
        MEM_CTRL_STATE_ACCEPT  = 2'd1,
        MEM_CTRL_STATE_WAIT    = 2'd2,
        MEM_CTRL_STATE_RESPOND = 2'd3
    } mem_ctrl_state_e;

    // A fill echoes port and address of the request; only data and flags change.
    function automatic logic [PACKET_WIDTH_BITS-1:0] build_fill(
        input logic [PACKET_WIDTH_BITS-1:0] req,
        input logic [DATA_HI-DATA_LO:0]     data
    );
        logic [PACKET_WIDTH_BITS-1:0] fill;
        fill                  = req;
        fill[DATA_HI:DATA_LO] = data;
        fill[IS_WRITE_POS]    = 1'b0;
        fill[VALID_POS]       = 1'b1;
        return fill;
    endfunction

endpackage

// File: rtl/unified_cache_mem_ctrl_if.sv
// Cache <-> memory packet bus: request/ack toward memory, fill/ack back to cache.
interface unified_cache_mem_ctrl_if
    import unified_cache_mem_ctrl_pkg::*;
#(
    parameter int W = PACKET_WIDTH_BITS
);
    logic [W-1:0] to_mem_packet_in;
    logic         to_mem_packet_ack_out;
    logic [W-1:0] from_mem_packet_out;
    logic         from_mem_packet_ack_in;

    modport master (
        output to_mem_packet_in,
        output from_mem_packet_ack_in,
        input  to_mem_packet_ack_out,
        input  from_mem_packet_out
    );

    modport slave (
        input  to_mem_packet_in,
        input  from_mem_packet_ack_in,
        output to_mem_packet_ack_out,
        output from_mem_packet_out
    );
endinterface

// File: rtl/unified_cache_mem_ctrl_store.sv
// Single-port block store with registered read; contents are never reset.
module unified_cache_mem_ctrl_store #(
    parameter int DATA_BITS  = 32,
    parameter int NUM_BLOCKS = 1024,
    parameter int INDEX_BITS = $clog2(NUM_BLOCKS)
) (
    input  logic                  i_clk,
    input  logic [INDEX_BITS-1:0] i_index,
    input  logic                  i_we,
    input  logic [DATA_BITS-1:0]  i_wdata,
    output logic [DATA_BITS-1:0]  o_rdata
);
    logic [DATA_BITS-1:0] r_mem [NUM_BLOCKS];
    logic [DATA_BITS-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_index] <= i_wdata;
        end
        r_rdata <= r_mem[i_index];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/unified_cache_mem_ctrl.sv
// Serialised main-memory stage: accepts one miss/writeback at a time and
// returns read fills after MEM_LATENCY cycles, held until the cache acks.
module unified_cache_mem_ctrl
    import unified_cache_mem_ctrl_pkg::*;
#(
    parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = PACKET_WIDTH_BITS,
    parameter int BLOCK_SIZE_IN_BYTES                = 4,
    parameter int NUM_BLOCKS                         = 1024,
    parameter int MEM_LATENCY                        = 8,
    parameter int LATENCY_CNT_WIDTH                  = $clog2(MEM_LATENCY) + 1
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    unified_cache_mem_ctrl_if.slave mem_bus
);
    localparam int W           = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE_IN_BYTES);
    localparam int INDEX_BITS  = $clog2(NUM_BLOCKS);
    localparam int DATA_BITS   = BLOCK_SIZE_IN_BYTES * 8;
    localparam logic [LATENCY_CNT_WIDTH-1:0] CNT_ONE  = LATENCY_CNT_WIDTH'(1);
    localparam logic [LATENCY_CNT_WIDTH-1:0] CNT_LOAD = LATENCY_CNT_WIDTH'(MEM_LATENCY - 1);

    mem_ctrl_state_e              r_state, w_next_state;
    logic [W-1:0]                 r_req;
    logic [W-1:0]                 r_fill;
    logic [W-1:0]                 w_fill;
    logic [LATENCY_CNT_WIDTH-1:0] r_cnt;
    logic                         r_idle_first;
    logic                         w_accept;
    logic                         w_fill_load;
    logic                         w_store_we;
    logic [INDEX_BITS-1:0]        w_index;
    logic [DATA_BITS-1:0]         w_rdata;

    // The first IDLE cycle after a transaction never latches, so a producer
    // still holding the request it just had acked is not serviced twice.
    assign w_accept   = (r_state == MEM_CTRL_STATE_IDLE) && !r_idle_first
                        && mem_bus.to_mem_packet_in[VALID_POS];
    assign w_store_we = (r_state == MEM_CTRL_STATE_ACCEPT) && r_req[IS_WRITE_POS];

    // While idle the RAM reads at the incoming index, so read data is ready
    // during ACCEPT even when MEM_LATENCY is 1.
    assign w_index = (r_state == MEM_CTRL_STATE_IDLE)
                   ? mem_bus.to_mem_packet_in[ADDR_LO + OFFSET_BITS +: INDEX_BITS]
                   : r_req[ADDR_LO + OFFSET_BITS +: INDEX_BITS];

    unified_cache_mem_ctrl_store #(
        .DATA_BITS  (DATA_BITS),
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_store (
        .i_clk   (clk_in),
        .i_index (w_index),
        .i_we    (w_store_we),
        .i_wdata (r_req[DATA_LO +: DATA_BITS]),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_next_state = r_state;
        w_fill_load  = 1'b0;
        w_fill       = build_fill(r_req, w_rdata);
        case (r_state)
            MEM_CTRL_STATE_IDLE: begin
                if (w_accept) begin
                    w_next_state = MEM_CTRL_STATE_ACCEPT;
                end
            end
            MEM_CTRL_STATE_ACCEPT: begin
                if (r_req[IS_WRITE_POS]) begin
                    w_next_state = MEM_CTRL_STATE_IDLE;
                end else if (MEM_LATENCY == 1) begin
                    w_next_state = MEM_CTRL_STATE_RESPOND;
                    w_fill_load  = 1'b1;
                end else begin
                    w_next_state = MEM_CTRL_STATE_WAIT;
                end
            end
            MEM_CTRL_STATE_WAIT: begin
                if (r_cnt == CNT_ONE) begin
                    w_next_state = MEM_CTRL_STATE_RESPOND;
                    w_fill_load  = 1'b1;
                end
            end
            MEM_CTRL_STATE_RESPOND: begin
                if (mem_bus.from_mem_packet_ack_in) begin
                    w_next_state = MEM_CTRL_STATE_IDLE;
                end
            end
            default: w_next_state = MEM_CTRL_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state      <= MEM_CTRL_STATE_IDLE;
            r_req        <= '0;
            r_fill       <= '0;
            r_cnt        <= '0;
            r_idle_first <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_idle_first <= (w_next_state == MEM_CTRL_STATE_IDLE)
                            && (r_state != MEM_CTRL_STATE_IDLE);
            if (w_accept) begin
                r_req <= mem_bus.to_mem_packet_in;
            end
            if (r_state == MEM_CTRL_STATE_ACCEPT) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == MEM_CTRL_STATE_WAIT) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
            if (w_fill_load) begin
                r_fill <= w_fill;
            end else if ((r_state == MEM_CTRL_STATE_RESPOND) && mem_bus.from_mem_packet_ack_in) begin
                r_fill <= '0;
            end
        end
    end

    assign mem_bus.to_mem_packet_ack_out = (r_state == MEM_CTRL_STATE_ACCEPT);
    assign mem_bus.from_mem_packet_out   = r_fill;
endmodule
